// File: rtl/sh_link_pkg.sv
// Shared link definitions: scheduler state encoding and packet geometry,
// used by link_sched and by the sync block.
package sh_link_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LISTEN    = 3'd1,
      RX_ACTIVE = 3'd2,
      GUARD     = 3'd3,
      TX_ARM    = 3'd4,
      TX_ACTIVE = 3'd5
   } link_state_t;

   localparam int PACKET_SIZE   = 64;
   localparam int PREAMBLE_SIZE = 8;
   localparam int TMR_W         = 16;
   localparam int PCNT_W        = 7;

   // A received packet includes one trailing sample beyond the payload.
   localparam logic [PCNT_W-1:0] RX_PULSES = PCNT_W'(PACKET_SIZE + 1);
   localparam logic [PCNT_W-1:0] TX_PULSES = PCNT_W'(PACKET_SIZE + PREAMBLE_SIZE);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter shared by the listen window, guard and timeout checks.
// expired is high during the last cycle of a loaded interval.
module link_timer
   import sh_link_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   // Load wins over decrement; the counter parks at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end else begin
         count <= count;
      end
   end

   assign expired = (count == W'(1));

endmodule

// File: rtl/link_sched.sv
// Half-duplex link scheduler: listen / receive / guard / transmit sequencing.
// Optional statistics counters are enabled with the LINK_SCHED_STATS_EN macro.
module link_sched
   import sh_link_pkg::*;
#(
   parameter int LISTEN_CYCLES = 20000,
   parameter int GUARD_CYCLES  = 1000,
   parameter int RX_TIMEOUT    = 14000,
   parameter int TX_TIMEOUT    = 12000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_req,
   input  logic        sh_en,
   input  logic        fsm_rst,
   output logic        RX,
   output logic        tx_rdy,
   output logic        tx_done,
   output logic        rx_done,
   output logic        timeout,
   output logic        busy,
   output logic [15:0] rx_pkt_cnt,
   output logic [15:0] tx_pkt_cnt,
   output logic [15:0] to_cnt
);

   link_state_t       state;
   link_state_t       nxt;
   logic [PCNT_W-1:0] pulse_cnt;
   logic [PCNT_W-1:0] cnt_inc;
   logic              tmr_reload;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_exp;
   logic              rx_ev;
   logic              tx_ev;
   logic              to_ev;

   assign cnt_inc = pulse_cnt + PCNT_W'(1);

   link_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   // Next-state decision; sh_en takes priority over a coincident timer expiry.
   always_comb begin
      nxt        = state;
      tmr_reload = 1'b0;
      rx_ev      = 1'b0;
      tx_ev      = 1'b0;
      to_ev      = 1'b0;
      case (state)
         IDLE: begin
            if (tx_req) begin
               nxt = TX_ARM;
            end else begin
               nxt = LISTEN;
            end
         end
         LISTEN: begin
            if (fsm_rst) begin
               nxt = RX_ACTIVE;
            end else if (tmr_exp) begin
               if (tx_req) begin
                  nxt = GUARD;
               end else begin
                  tmr_reload = 1'b1;
               end
            end else begin
               nxt = LISTEN;
            end
         end
         RX_ACTIVE: begin
            if (sh_en) begin
               if (cnt_inc == RX_PULSES) begin
                  rx_ev = 1'b1;
                  nxt   = GUARD;
               end else begin
                  tmr_reload = 1'b1;
               end
            end else if (tmr_exp) begin
               to_ev = 1'b1;
               nxt   = GUARD;
            end else begin
               nxt = RX_ACTIVE;
            end
         end
         GUARD: begin
            if (tmr_exp) begin
               if (tx_req) begin
                  nxt = TX_ARM;
               end else begin
                  nxt = LISTEN;
               end
            end else begin
               nxt = GUARD;
            end
         end
         TX_ARM: begin
            nxt = TX_ACTIVE;
         end
         TX_ACTIVE: begin
            if (sh_en) begin
               if (cnt_inc == TX_PULSES) begin
                  tx_ev = 1'b1;
                  nxt   = GUARD;
               end else begin
                  tmr_reload = 1'b1;
               end
            end else if (tmr_exp) begin
               to_ev = 1'b1;
               nxt   = GUARD;
            end else begin
               nxt = TX_ACTIVE;
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   // Every state change (and every in-state restart) reloads the single timer.
   always_comb begin
      tmr_load = (nxt != state) || tmr_reload;
      case (nxt)
         LISTEN:    tmr_val = TMR_W'(LISTEN_CYCLES);
         RX_ACTIVE: tmr_val = TMR_W'(RX_TIMEOUT);
         GUARD:     tmr_val = TMR_W'(GUARD_CYCLES);
         TX_ACTIVE: tmr_val = TMR_W'(TX_TIMEOUT);
         default:   tmr_val = '0;
      endcase
   end

   // State register with outputs registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         RX        <= 1'b0;
         tx_rdy    <= 1'b0;
         tx_done   <= 1'b0;
         rx_done   <= 1'b0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state   <= nxt;
         RX      <= (nxt == LISTEN) || (nxt == RX_ACTIVE);
         tx_rdy  <= (nxt == TX_ARM);
         tx_done <= tx_ev;
         rx_done <= rx_ev;
         timeout <= to_ev;
         busy    <= (nxt != IDLE);
         if (nxt != state) begin
            pulse_cnt <= '0;
         end else if (sh_en && ((state == RX_ACTIVE) || (state == TX_ACTIVE))) begin
            pulse_cnt <= cnt_inc;
         end else begin
            pulse_cnt <= pulse_cnt;
         end
      end
   end

`ifdef LINK_SCHED_STATS_EN
   // Saturating packet statistics, updated together with the status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_pkt_cnt <= 16'd0;
         tx_pkt_cnt <= 16'd0;
         to_cnt     <= 16'd0;
      end else begin
         rx_pkt_cnt <= rx_ev ? sat_inc16(rx_pkt_cnt) : rx_pkt_cnt;
         tx_pkt_cnt <= tx_ev ? sat_inc16(tx_pkt_cnt) : tx_pkt_cnt;
         to_cnt     <= to_ev ? sat_inc16(to_cnt)     : to_cnt;
      end
   end
`else
   assign rx_pkt_cnt = 16'd0;
   assign tx_pkt_cnt = 16'd0;
   assign to_cnt     = 16'd0;
`endif

endmodule
